// File: rtl/deck_pkg.sv
// Shared types and card helpers for the deck dealer.
// Card index idx encodes suit = idx/13 and rank = idx%13 + 1.
package deck_pkg;

   typedef enum logic [1:0] {
      INIT,
      SHUFFLE,
      READY
   } state_t;

   localparam int          DECK_SIZE = 52;
   localparam int          RANKS     = 13;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [1:0] idx_to_suit(input logic [5:0] idx);
      if (idx >= 6'(3 * RANKS)) return 2'd3;
      if (idx >= 6'(2 * RANKS)) return 2'd2;
      if (idx >= 6'(RANKS))     return 2'd1;
      return 2'd0;
   endfunction

   function automatic logic [3:0] idx_to_rank(input logic [5:0] idx);
      return 4'(idx - 6'(idx_to_suit(idx)) * 6'(RANKS) + 6'd1);
   endfunction

   function automatic logic [3:0] rank_to_value(input logic [3:0] rank);
      return (rank > 4'd10) ? 4'd10 : rank;
   endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR, free-running outside reset.
// Shared by the random sources of the game.
module lfsr16
   import deck_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   output logic [15:0] q
);

   logic [15:0] q_q;
   logic [15:0] q_d;

   always_comb begin
      q_d = q_q >> 1;
      if (q_q[0]) q_d = q_d ^ LFSR_TAPS;
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) q_q <= SEED;
      else       q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: rtl/deck_dealer.sv
// 52-card deck: ordered init, LFSR swap shuffle, one card per request.
// All outputs come straight from flops.
module deck_dealer
   import deck_pkg::*;
#(
   parameter int          SHUFFLE_LIMIT = 104,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       shuffle_req,
   input  logic       card_req,
   output logic       ready,
   output logic       card_valid,
   output logic [3:0] card_rank,
   output logic [1:0] card_suit,
   output logic [3:0] card_value,
   output logic [5:0] cards_left,
   output logic       deck_empty
);

   localparam logic [15:0] LIMIT = 16'(SHUFFLE_LIMIT);
   localparam logic [5:0]  LAST  = 6'(DECK_SIZE - 1);
   localparam logic [5:0]  FULL  = 6'(DECK_SIZE);

   logic [15:0] lfsr;
   logic [5:0]  r;
   logic        lfsr_unused;

   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .q        (lfsr)
   );

   assign r           = lfsr[5:0];
   assign lfsr_unused = ^lfsr[15:6];

   state_t      state_q, state_d;
   logic [5:0]  deck_q [DECK_SIZE];
   logic [5:0]  deck_d [DECK_SIZE];
   logic [5:0]  i_q, i_d;
   logic [5:0]  ptr_q, ptr_d;
   logic [15:0] swap_q, swap_d;
   logic        ready_q, ready_d;
   logic        valid_q, valid_d;
   logic [3:0]  rank_q, rank_d;
   logic [1:0]  suit_q, suit_d;
   logic [3:0]  value_q, value_d;
   logic [5:0]  left_q, left_d;
   logic        empty_q, empty_d;

   always_comb begin
      state_d = state_q;
      deck_d  = deck_q;
      i_d     = i_q;
      ptr_d   = ptr_q;
      swap_d  = swap_q;
      valid_d = 1'b0;
      rank_d  = rank_q;
      suit_d  = suit_q;
      value_d = value_q;
      left_d  = left_q;

      unique case (state_q)
         INIT: begin
            deck_d[i_q] = i_q;
            if (i_q == LAST) begin
               i_d     = '0;
               swap_d  = '0;
               state_d = SHUFFLE;
            end else begin
               i_d = i_q + 6'd1;
            end
         end
         SHUFFLE: begin
            if (swap_q == LIMIT) begin
               state_d = READY;
               ptr_d   = '0;
               left_d  = FULL;
            end else if (r < FULL) begin
               // r == i_q degenerates to a no-op swap
               deck_d[i_q] = deck_q[r];
               deck_d[r]   = deck_q[i_q];
               i_d         = (i_q == LAST) ? 6'd0 : i_q + 6'd1;
               swap_d      = swap_q + 16'd1;
            end
         end
         READY: begin
            if (shuffle_req) begin
               state_d = INIT;
               i_d     = '0;
            end else if (card_req && ptr_q < FULL) begin
               valid_d = 1'b1;
               rank_d  = idx_to_rank(deck_q[ptr_q]);
               suit_d  = idx_to_suit(deck_q[ptr_q]);
               value_d = rank_to_value(idx_to_rank(deck_q[ptr_q]));
               ptr_d   = ptr_q + 6'd1;
               left_d  = left_q - 6'd1;
            end
         end
         default: state_d = INIT;
      endcase

      ready_d = (state_d == READY);
      empty_d = (state_d == READY) && (left_d == 6'd0);
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q <= INIT;
         deck_q  <= '{default: '0};
         i_q     <= '0;
         ptr_q   <= '0;
         swap_q  <= '0;
         ready_q <= 1'b0;
         valid_q <= 1'b0;
         rank_q  <= '0;
         suit_q  <= '0;
         value_q <= '0;
         left_q  <= '0;
         empty_q <= 1'b0;
      end else begin
         state_q <= state_d;
         deck_q  <= deck_d;
         i_q     <= i_d;
         ptr_q   <= ptr_d;
         swap_q  <= swap_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
         rank_q  <= rank_d;
         suit_q  <= suit_d;
         value_q <= value_d;
         left_q  <= left_d;
         empty_q <= empty_d;
      end
   end

   assign ready      = ready_q;
   assign card_valid = valid_q;
   assign card_rank  = rank_q;
   assign card_suit  = suit_q;
   assign card_value = value_q;
   assign cards_left = left_q;
   assign deck_empty = empty_q;

endmodule

// File: tb/tb_deck_dealer.sv
// Bench for deck_dealer: identity deck (limit 0) and shuffled deck (limit 4)
// checked against a card-level reference model of the shuffle.
module tb_deck_dealer;

   localparam logic [15:0] SEED = 16'hACE1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0] rst  = 2'b11;
   logic [1:0] sreq = 2'b00;
   logic [1:0] creq = 2'b00;
   logic [1:0] rdy, cv, de;
   logic [3:0] rk [2];
   logic [1:0] st [2];
   logic [3:0] vl [2];
   logic [5:0] cl [2];

   deck_dealer #(.SHUFFLE_LIMIT(0), .LFSR_SEED(SEED)) u_dut0 (
      .CLOCK_50    (clk),
      .reset       (rst[0]),
      .shuffle_req (sreq[0]),
      .card_req    (creq[0]),
      .ready       (rdy[0]),
      .card_valid  (cv[0]),
      .card_rank   (rk[0]),
      .card_suit   (st[0]),
      .card_value  (vl[0]),
      .cards_left  (cl[0]),
      .deck_empty  (de[0])
   );

   deck_dealer #(.SHUFFLE_LIMIT(4), .LFSR_SEED(SEED)) u_dut4 (
      .CLOCK_50    (clk),
      .reset       (rst[1]),
      .shuffle_req (sreq[1]),
      .card_req    (creq[1]),
      .ready       (rdy[1]),
      .card_valid  (cv[1]),
      .card_rank   (rk[1]),
      .card_suit   (st[1]),
      .card_value  (vl[1]),
      .cards_left  (cl[1]),
      .deck_empty  (de[1])
   );

   int n_pass = 0;
   int n_chk  = 0;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   function automatic logic [15:0] lstep(input logic [15:0] v);
      return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
   endfunction

   // Reference LFSR per instance, tracked from the clock and reset alone.
   logic [15:0] m_l [2];
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++)
         m_l[d] <= rst[d] ? SEED : lstep(m_l[d]);
   end

   int exp_ord [52];
   int exp_cyc;
   int clean_ord [52];
   int clean_cyc;

   // Deck order and edge count to ready, starting from the first INIT edge.
   task automatic predict(input logic [15:0] start, input int limit);
      logic [15:0] l;
      int acc, ic, r, t;
      l = start; acc = 0; ic = 0;
      for (int i = 0; i < 52; i++) begin
         exp_ord[i] = i;
         l = lstep(l);
      end
      exp_cyc = 52;
      while (acc < limit) begin
         r = int'(l[5:0]);
         if (r < 52) begin
            t = exp_ord[ic];
            exp_ord[ic] = exp_ord[r];
            exp_ord[r] = t;
            ic = (ic + 1) % 52;
            acc++;
         end
         l = lstep(l);
         exp_cyc++;
      end
      exp_cyc++;
   endtask

   task automatic check_reset(input int d);
      check("rst_ready", rdy[d], 0);
      check("rst_valid", cv[d], 0);
      check("rst_rank", rk[d], 0);
      check("rst_suit", st[d], 0);
      check("rst_value", vl[d], 0);
      check("rst_left", cl[d], 0);
      check("rst_empty", de[d], 0);
   endtask

   task automatic wait_ready(input int d, input bit noise);
      int e;
      e = 0;
      forever begin
         @(posedge clk); #1;
         creq[d] = 1'b0;
         sreq[d] = 1'b0;
         e++;
         if (rdy[d] === 1'b1) break;
         if (e > 2000) break;
         if (noise) begin
            check("no_card_busy", cv[d], 0);
            creq[d] = 1'($urandom_range(0, 1));
            if (e >= 52) sreq[d] = ($urandom_range(0, 3) == 0);
         end
      end
      check("ready_edge", e, exp_cyc);
   endtask

   task automatic deal(input int d, input int idx);
      int rank;
      rank = idx % 13 + 1;
      creq[d] = 1'b1;
      @(posedge clk); #1;
      creq[d] = 1'b0;
      check("card_valid", cv[d], 1);
      check("card_rank", rk[d], rank);
      check("card_suit", st[d], idx / 13);
      check("card_value", vl[d], (rank > 10) ? 10 : rank);
   endtask

   task automatic deal_n(input int d, input int n);
      bit seen [52];
      int g;
      for (int i = 0; i < 52; i++) seen[i] = 1'b0;
      for (int i = 0; i < n; i++) begin
         g = $urandom_range(0, 2);
         for (int k = 0; k < g; k++) begin
            @(posedge clk); #1;
            if (k == 0 && i > 0) check("valid_pulse", cv[d], 0);
         end
         deal(d, exp_ord[i]);
         check("cards_left", cl[d], 51 - i);
         check("unique_card", seen[exp_ord[i]], 0);
         seen[exp_ord[i]] = 1'b1;
      end
   endtask

   task automatic reshuffle(input int d, input bit with_card);
      logic [3:0] r_before;
      r_before = rk[d];
      sreq[d] = 1'b1;
      creq[d] = with_card;
      @(posedge clk); #1;
      sreq[d] = 1'b0;
      creq[d] = 1'b0;
      check("shuf_no_card", cv[d], 0);
      check("shuf_ready_low", rdy[d], 0);
      check("shuf_rank_hold", rk[d], r_before);
      predict(m_l[d], 4);
      wait_ready(d, 1'b0);
      check("shuf_left", cl[d], 52);
      check("shuf_empty", de[d], 0);
   endtask

   initial begin
      int k;

      repeat (3) @(posedge clk);
      #1;
      check_reset(0);
      check_reset(1);

      // Identity deck
      @(negedge clk); rst[0] = 1'b0;
      predict(SEED, 0);
      wait_ready(0, 1'b0);
      check("id_left", cl[0], 52);
      check("id_empty0", de[0], 0);
      deal_n(0, 52);
      check("id_empty1", de[0], 1);
      check("id_left0", cl[0], 0);
      creq[0] = 1'b1;
      @(posedge clk); #1;
      creq[0] = 1'b0;
      check("over_valid", cv[0], 0);
      check("over_rank", rk[0], 13);
      check("over_suit", st[0], 3);
      check("over_value", vl[0], 10);
      check("over_left", cl[0], 0);
      check("over_empty", de[0], 1);

      // Shuffled deck with ignored requests during INIT/SHUFFLE
      @(negedge clk); rst[1] = 1'b0;
      predict(SEED, 4);
      clean_ord = exp_ord;
      clean_cyc = exp_cyc;
      wait_ready(1, 1'b1);
      deal_n(1, 52);
      check("sh_empty", de[1], 1);

      reshuffle(1, 1'b0);
      deal_n(1, 5);
      reshuffle(1, 1'b1);
      deal_n(1, 3);

      // Reset in the middle of SHUFFLE
      rst[1] = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_reset(1);
      @(negedge clk); rst[1] = 1'b0;
      k = $urandom_range(53, clean_cyc - 1);
      repeat (k) @(posedge clk);
      #1;
      check("mid_not_ready", rdy[1], 0);
      rst[1] = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_reset(1);
      @(negedge clk); rst[1] = 1'b0;
      predict(SEED, 4);
      wait_ready(1, 1'b0);
      check("restart_edges", exp_cyc, clean_cyc);
      exp_ord = clean_ord;
      deal_n(1, 52);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
